sign_mag_addsub_serial: RTL and testbench

Parametrised, digit-serial sign-magnitude adder/subtractor; the sequential successor of the 8/16-bit ripple-borrow subtractors. It accepts two sign-magnitude operands over a valid/ready handshake and processes DIGIT magnitude bits per cycle through a registered borrow/carry chain. When the magnitude difference is negative, it runs a second digit-serial pass to negate the result. It sits between operand registers and result consumers in the sign-magnitude datapath.

---
 rtl/sign_mag_addsub_serial_pkg.sv | 8 +
 rtl/sign_mag_addsub_serial_if.sv | 15 +
 rtl/sign_mag_addsub_serial_digit_addsub.sv | 16 +
 rtl/sign_mag_addsub_serial.sv | 113 +++++++++++
 tb/tb_sign_mag_addsub_serial.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/sign_mag_addsub_serial_pkg.sv
// sign_mag_pkg: shared state encoding and mode/sign constants for the serial sign-magnitude add/sub
package sign_mag_pkg;
    typedef enum logic [2:0] {IDLE, ADD, SUB, NEG, DONE} state_e;
    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;
    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;
endpackage

// File: rtl/sign_mag_addsub_serial_if.sv
// sign_mag_addsub_serial_if: operand/result handshake bundle
// master drives in_valid/A/B/mode/out_ready; slave drives in_ready/out_valid/Result/overflow
interface sign_mag_addsub_serial_if #(parameter int MAG_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W:0]   A;
    logic [MAG_W:0]   B;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [MAG_W:0]   Result;
    logic             overflow;
    modport master (output in_valid, A, B, mode, out_ready, input in_ready, out_valid, Result, overflow);
    modport slave  (input in_valid, A, B, mode, out_ready, output in_ready, out_valid, Result, overflow);
endinterface

// File: rtl/sign_mag_addsub_serial_digit_addsub.sv
// digit_addsub: one DIGIT-wide add (sub_i=0) or subtract (sub_i=1) slice with carry/borrow
// x_i, y_i: digits; c_i: carry-in or borrow-in; r_o: result digit; c_o: carry-out or borrow-out
module digit_addsub #(parameter int DIGIT = 4) (
    input  logic [DIGIT-1:0] x_i,
    input  logic [DIGIT-1:0] y_i,
    input  logic             sub_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] r_o,
    output logic             c_o
);
    logic [DIGIT:0] t;
    // on subtract the extra top bit goes to 1 exactly when the difference underflows
    assign t = sub_i ? {1'b0, x_i} - {1'b0, y_i} - {{DIGIT{1'b0}}, c_i}
                     : {1'b0, x_i} + {1'b0, y_i} + {{DIGIT{1'b0}}, c_i};
    assign {c_o, r_o} = t;
endmodule

// File: rtl/sign_mag_addsub_serial.sv
// sign_mag_addsub_serial: digit-serial sign-magnitude adder/subtractor with in-place negate pass
// clk: clock; rst_n: async active-low reset; bus: slave side of the operand/result handshake
module sign_mag_addsub_serial
    import sign_mag_pkg::*;
#(
    parameter int MAG_W = 16,
    parameter int DIGIT = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    sign_mag_addsub_serial_if.slave bus
);
    localparam int N  = MAG_W / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (MAG_W % DIGIT != 0) begin : g_chk
        $error("MAG_W must be a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [MAG_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             sign_q, sign_d, ovf_q, ovf_d, c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT-1:0] dx, dy, dr;
    logic             dco, sa, sb, last;
    logic [MAG_W+DIGIT-1:0] shift;

    // NEG reuses the slice as 0 - digit, reading the low digit of the result being rotated
    assign dx = state_q == NEG ? '0 : a_q[DIGIT-1:0];
    assign dy = state_q == NEG ? res_q[DIGIT-1:0] : b_q[DIGIT-1:0];

    digit_addsub #(.DIGIT(DIGIT)) u_digit (
        .x_i(dx), .y_i(dy), .sub_i(state_q != ADD), .c_i(c_q), .r_o(dr), .c_o(dco)
    );

    // a negative zero operand behaves as positive zero
    assign sa    = bus.A[MAG_W] & |bus.A[MAG_W-1:0];
    assign sb    = bus.B[MAG_W] & |bus.B[MAG_W-1:0];
    assign last  = cnt_q == CW'(N - 1);
    assign shift = {dr, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.A[MAG_W-1:0];
                b_d     = bus.B[MAG_W-1:0];
                sign_d  = sa;
                res_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = '0;
                c_d     = 1'b0;
                state_d = (sa ^ sb ^ (bus.mode == MODE_SUB)) ? SUB : ADD;
            end
            ADD, SUB, NEG: begin
                // operands shift right one digit per cycle; result digits enter at the top
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = shift[MAG_W+DIGIT-1:DIGIT];
                c_d   = dco;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    cnt_d = '0;
                    c_d   = 1'b0;
                    if (state_q == SUB && dco) begin
                        sign_d  = ~sign_q;
                        state_d = NEG;
                    end else begin
                        ovf_d   = state_q == ADD && dco;
                        sign_d  = (res_d == '0 && !ovf_d) ? SIGN_POS : sign_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sign_q  <= SIGN_POS;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.Result    = {sign_q, res_q};
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sign_mag_addsub_serial.sv
// tb_sign_mag_addsub_serial: directed checks of the serial sign-magnitude add/sub (MAG_W=16, DIGIT=4)
module tb_sign_mag_addsub_serial;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sign_mag_addsub_serial_if #(.MAG_W(16)) bus ();

    sign_mag_addsub_serial #(.MAG_W(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [16:0] a, input logic [16:0] b, input logic m);
        chk({tag, "_ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.mode     = m;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_ready_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_done(input string tag, input logic [16:0] res, input logic ovf, input int lat_exp);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_result"}, 32'(bus.Result), 32'(res));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(ovf));
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.Result), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        start("sub_pos", 17'h00005, 17'h00003, 1'b0);
        wait_done("sub_pos", 17'h00002, 1'b0, 4);
        release_result("sub_pos");

        start("sub_neg", 17'h00003, 17'h00005, 1'b0);
        wait_done("sub_neg", 17'h10002, 1'b0, 8);
        release_result("sub_neg");

        start("mix_ovf", 17'h08000, 17'h18000, 1'b0);
        wait_done("mix_ovf", 17'h00000, 1'b1, 4);
        release_result("mix_ovf");

        start("zero_sub", 17'h10007, 17'h10007, 1'b0);
        wait_done("zero_sub", 17'h00000, 1'b0, 4);
        release_result("zero_sub");

        start("neg_zero", 17'h10000, 17'h00000, 1'b1);
        wait_done("neg_zero", 17'h00000, 1'b0, 4);
        release_result("neg_zero");

        start("add_negs", 17'h11234, 17'h10100, 1'b1);
        wait_done("add_negs", 17'h11334, 1'b0, 4);
        release_result("add_negs");

        start("add_wrap", 17'h1FFFF, 17'h10002, 1'b1);
        wait_done("add_wrap", 17'h10001, 1'b1, 4);
        release_result("add_wrap");

        start("sub_flip", 17'h10003, 17'h10100, 1'b0);
        wait_done("sub_flip", 17'h000FD, 1'b0, 8);
        release_result("sub_flip");

        start("bp", 17'h01234, 17'h00011, 1'b1);
        wait_done("bp", 17'h01245, 1'b0, 4);
        bus.in_valid = 1'b1;
        bus.A        = 17'h00001;
        bus.B        = 17'h00002;
        bus.mode     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_result", 32'(bus.Result), 32'h01245);
            chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_ready_next", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accepted", 32'(bus.in_ready), 32'd0);
        wait_done("bp_new", 17'h00003, 1'b0, 4);
        release_result("bp_new");

        start("rst_neg", 17'h00001, 17'h0FFFF, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_neg_busy", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_neg_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_neg_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_neg_result", 32'(bus.Result), 32'd0);
        chk("rst_neg_overflow", 32'(bus.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rel_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_rel_valid", 32'(bus.out_valid), 32'd0);
        start("fresh", 17'h00009, 17'h00004, 1'b1);
        wait_done("fresh", 17'h0000D, 1'b0, 4);
        release_result("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
